// File: rtl/x4xx_mgt_pkt_checker.sv
// Receive-side MGT loopback checker: verifies sequence, length and lane pattern
// of each AXI-Stream frame, and counts good/bad frames until NUM_PKTS are judged.
module x4xx_mgt_pkt_checker #(
  parameter int DATA_W      = 64,
  parameter int NUM_PKTS    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [15:0]       good_count,
  output logic [15:0]       err_count,
  output logic [3:0]        err_flags,
  output logic              done
);

  localparam int          LANES      = DATA_W / 16;
  localparam logic [16:0] TOTAL_DONE = 17'(NUM_PKTS);
  localparam logic        TMO_EN     = (TIMEOUT_CYC > 0);
  localparam logic [31:0] TMO_LAST   = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic lanes_match(input logic [DATA_W-1:0] d, input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      ok = ok & (d[16*l +: 16] == w);
    end
    return ok;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_r;
  logic [15:0] exp_seq_r;
  logic [15:0] exp_word_r;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [2:0]  pend_r;      // per-frame {data, length, seq} errors seen so far
  logic [31:0] tmo_cnt_r;
  logic [16:0] total_r;     // unsaturated judged-frame count for done

  logic        accept_s;
  logic [15:0] hdr_seq_s;
  logic [15:0] hdr_len_s;
  logic        last_idx_s;
  logic        tmo_hit_s;
  logic        judge_s;
  logic [3:0]  jflags_s;
  state_t      nxt_state_s;
  logic [15:0] nxt_idx_s;
  logic [2:0]  nxt_pend_s;

  // Per-beat frame checks and next-state decision
  always_comb begin
    accept_s    = s_axis_tvalid & s_axis_tready;
    hdr_seq_s   = s_axis_tdata[15:0];
    hdr_len_s   = s_axis_tdata[31:16];
    last_idx_s  = (idx_r == (len_r - 16'd1));
    tmo_hit_s   = TMO_EN & ~s_axis_tvalid & (tmo_cnt_r == TMO_LAST);
    judge_s     = 1'b0;
    jflags_s    = 4'b0000;
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    nxt_pend_s  = pend_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          nxt_pend_s = {1'b0, 1'b0, (hdr_seq_s != exp_seq_r)};
          nxt_idx_s  = 16'd1;
          if (s_axis_tlast) begin
            nxt_pend_s[1] = (hdr_len_s != 16'd1);
            judge_s       = 1'b1;
            jflags_s      = {1'b0, nxt_pend_s};
            nxt_state_s   = ST_IDLE;
          end else if (hdr_len_s <= 16'd1) begin
            nxt_pend_s[1] = 1'b1;
            nxt_state_s   = ST_DROP;
          end else begin
            nxt_state_s = ST_PAYLOAD;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          nxt_pend_s[2] = pend_r[2] | ~lanes_match(s_axis_tdata, exp_word_r);
          nxt_idx_s     = idx_r + 16'd1;
          if (s_axis_tlast) begin
            nxt_pend_s[1] = pend_r[1] | ~last_idx_s;
            judge_s       = 1'b1;
            jflags_s      = {1'b0, nxt_pend_s};
            nxt_state_s   = ST_IDLE;
          end else if (last_idx_s) begin
            nxt_pend_s[1] = 1'b1;
            nxt_state_s   = ST_DROP;
          end else begin
            nxt_state_s = ST_PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          judge_s     = 1'b1;
          jflags_s    = 4'b1000;
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          judge_s     = 1'b1;
          jflags_s    = {1'b0, pend_r};
          nxt_state_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          judge_s     = 1'b1;
          jflags_s    = 4'b1000;
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_DROP;
        end
      end
      ST_DONE: begin
        nxt_state_s = ST_DONE;
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Checker state, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      exp_seq_r     <= 16'd0;
      exp_word_r    <= 16'd0;
      len_r         <= 16'd0;
      idx_r         <= 16'd0;
      pend_r        <= 3'b000;
      tmo_cnt_r     <= 32'd0;
      total_r       <= 17'd0;
      s_axis_tready <= 1'b0;
      good_count    <= 16'd0;
      err_count     <= 16'd0;
      err_flags     <= 4'b0000;
      done          <= 1'b0;
    end else if (clear) begin
      state_r       <= ST_IDLE;
      exp_seq_r     <= 16'd0;
      exp_word_r    <= 16'd0;
      len_r         <= 16'd0;
      idx_r         <= 16'd0;
      pend_r        <= 3'b000;
      tmo_cnt_r     <= 32'd0;
      total_r       <= 17'd0;
      s_axis_tready <= 1'b1;
      good_count    <= 16'd0;
      err_count     <= 16'd0;
      err_flags     <= 4'b0000;
      done          <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      idx_r         <= nxt_idx_s;
      pend_r        <= nxt_pend_s;
      s_axis_tready <= (nxt_state_s != ST_DONE);

      // Expected seq resyncs to the received header, not the predicted one
      if ((state_r == ST_IDLE) && accept_s) begin
        exp_seq_r  <= hdr_seq_s + 16'd1;
        exp_word_r <= hdr_seq_s + 16'd1;
        len_r      <= hdr_len_s;
      end else if ((state_r == ST_PAYLOAD) && accept_s) begin
        exp_word_r <= exp_word_r + 16'd1;
      end else begin
        exp_word_r <= exp_word_r;
      end

      if (TMO_EN && ((state_r == ST_PAYLOAD) || (state_r == ST_DROP)) && !s_axis_tvalid) begin
        tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end else begin
        tmo_cnt_r <= 32'd0;
      end

      if (judge_s) begin
        total_r   <= total_r + 17'd1;
        err_flags <= err_flags | jflags_s;
        if (|jflags_s) begin
          err_count <= sat_inc(err_count);
        end else begin
          good_count <= sat_inc(good_count);
        end
        if ((total_r + 17'd1) == TOTAL_DONE) begin
          done          <= 1'b1;
          state_r       <= ST_DONE;
          s_axis_tready <= 1'b0;
        end else begin
          done <= done;
        end
      end else begin
        total_r <= total_r;
      end
    end
  end

endmodule

// File: tb/tb_x4xx_mgt_pkt_checker.sv
// Directed bench for x4xx_mgt_pkt_checker: a frame-level model judged per frame,
// compared every cycle, plus literal expectations after each scenario.
module tb_x4xx_mgt_pkt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n   = 1'b0;
  logic         clear_a = 1'b0;
  logic         clear_b = 1'b0;
  logic         valid_a = 1'b0;
  logic         valid_b = 1'b0;
  logic         last    = 1'b0;
  logic [511:0] tdata   = '0;

  logic        rdy_a, rdy_b, done_a, done_b;
  logic [15:0] good_a, err_a, good_b, err_b;
  logic [3:0]  flags_a, flags_b;

  int tests = 0;
  int fails = 0;

  x4xx_mgt_pkt_checker #(.DATA_W(64), .NUM_PKTS(16), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a),
    .s_axis_tdata(tdata[63:0]), .s_axis_tlast(last), .s_axis_tvalid(valid_a),
    .s_axis_tready(rdy_a), .good_count(good_a), .err_count(err_a),
    .err_flags(flags_a), .done(done_a));

  x4xx_mgt_pkt_checker #(.DATA_W(512), .NUM_PKTS(4), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b),
    .s_axis_tdata(tdata), .s_axis_tlast(last), .s_axis_tvalid(valid_b),
    .s_axis_tready(rdy_b), .good_count(good_b), .err_count(err_b),
    .err_flags(flags_b), .done(done_b));

  // ---------------- frame-level model ----------------
  logic        m_rdy[2], m_done[2], m_serr[2], m_derr[2];
  logic [15:0] m_good[2], m_err[2], m_exp[2], m_seq[2], m_len[2];
  logic [3:0]  m_flags[2];
  int          m_total[2], m_n[2], m_idle[2];

  function automatic int lanes_of(input int k); return (k == 0) ? 4 : 32; endfunction
  function automatic int np_of(input int k);    return (k == 0) ? 16 : 4; endfunction
  function automatic int to_of(input int k);    return (k == 0) ? 8 : 0; endfunction

  task automatic model_clear(input int k, input logic rdy);
    m_rdy[k] = rdy; m_done[k] = 1'b0; m_serr[k] = 1'b0; m_derr[k] = 1'b0;
    m_good[k] = 16'd0; m_err[k] = 16'd0; m_exp[k] = 16'd0; m_seq[k] = 16'd0;
    m_len[k] = 16'd0; m_flags[k] = 4'd0; m_total[k] = 0; m_n[k] = 0; m_idle[k] = 0;
  endtask

  task automatic judge(input int k, input logic [3:0] f);
    m_total[k]++;
    if (f != 4'd0) m_err[k] = (m_err[k] == 16'hFFFF) ? m_err[k] : m_err[k] + 16'd1;
    else m_good[k] = (m_good[k] == 16'hFFFF) ? m_good[k] : m_good[k] + 16'd1;
    m_flags[k] = m_flags[k] | f;
    if (m_total[k] == np_of(k)) m_done[k] = 1'b1;
    m_n[k] = 0;
    m_idle[k] = 0;
  endtask

  task automatic model_step(input int k, input logic v, input logic clr);
    logic [15:0] want;
    if (clr) begin
      model_clear(k, 1'b1);
    end else begin
      if (v && m_rdy[k]) begin
        if (m_n[k] == 0) begin
          m_seq[k]  = tdata[15:0];
          m_len[k]  = tdata[31:16];
          m_serr[k] = (tdata[15:0] != m_exp[k]);
          m_exp[k]  = tdata[15:0] + 16'd1;
          m_derr[k] = 1'b0;
        end else if (m_n[k] < int'(m_len[k])) begin
          want = m_seq[k] + 16'(m_n[k]);
          for (int l = 0; l < lanes_of(k); l++)
            if (tdata[16*l +: 16] != want) m_derr[k] = 1'b1;
        end
        m_n[k]++;
        m_idle[k] = 0;
        if (last) judge(k, {1'b0, m_derr[k], (m_n[k] != int'(m_len[k])), m_serr[k]});
      end else if (m_n[k] > 0 && !v) begin
        m_idle[k]++;
        if (to_of(k) > 0 && m_idle[k] == to_of(k)) judge(k, 4'b1000);
      end
      m_rdy[k] = !m_done[k];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0, 1'b0);
      model_clear(1, 1'b0);
    end else begin
      model_step(0, valid_a, clear_a);
      model_step(1, valid_b, clear_b);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic r, input logic [15:0] g, input logic [15:0] e,
                     input logic [3:0] f, input logic d);
    string p;
    p = (k == 0) ? "a" : "b";
    check({p, ".tready"},     32'(r), 32'(m_rdy[k]));
    check({p, ".good_count"}, 32'(g), 32'(m_good[k]));
    check({p, ".err_count"},  32'(e), 32'(m_err[k]));
    check({p, ".err_flags"},  32'(f), 32'(m_flags[k]));
    check({p, ".done"},       32'(d), 32'(m_done[k]));
  endtask

  always @(negedge clk) begin
    cmp(0, rdy_a, good_a, err_a, flags_a, done_a);
    cmp(1, rdy_b, good_b, err_b, flags_b, done_b);
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int k, input logic [15:0] seq, input logic [15:0] len,
                            input int nb, input bit with_last, input int bad_beat, input int bad_lane);
    for (int i = 0; i < nb; i++) begin
      tdata = '0;
      if (i == 0) begin
        tdata[15:0]  = seq;
        tdata[31:16] = len;
      end else begin
        for (int l = 0; l < 32; l++) tdata[16*l +: 16] = seq + 16'(i);
      end
      if (i == bad_beat) tdata[16*bad_lane +: 16] = 16'hDEAD;
      last = with_last && (i == nb - 1);
      if (k == 0) valid_a = 1'b1; else valid_b = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    valid_a = 1'b0; valid_b = 1'b0; last = 1'b0; tdata = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear_a();
    valid_a = 1'b0; clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.tready",  32'(rdy_a), 32'd0);
    check("rst.good",    32'(good_a), 32'd0);
    check("rst.flags",   32'(flags_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel.tready_before_edge", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    check("rel.tready_a", 32'(rdy_a), 32'd1);
    check("rel.tready_b", 32'(rdy_b), 32'd1);

    // 512-bit data corruption, then fill up to done
    send_frame(1, 16'd0, 16'd4, 4, 1'b1, 2, 3);
    send_frame(1, 16'd1, 16'd3, 3, 1'b1, -1, -1);
    idle(2);
    check("data.err",   32'(err_b), 32'd1);
    check("data.good",  32'(good_b), 32'd1);
    check("data.flags", 32'(flags_b), 32'h4);
    send_frame(1, 16'd2, 16'd2, 2, 1'b1, -1, -1);
    send_frame(1, 16'd3, 16'd2, 2, 1'b1, -1, -1);
    idle(1);
    check("b.done",   32'(done_b), 32'd1);
    check("b.tready", 32'(rdy_b), 32'd0);

    // 16 good back-to-back frames
    for (int s = 0; s < 16; s++) send_frame(0, 16'(s), 16'd4, 4, 1'b1, -1, -1);
    check("run.done",   32'(done_a), 32'd1);
    check("run.good",   32'(good_a), 32'd16);
    check("run.err",    32'(err_a), 32'd0);
    check("run.flags",  32'(flags_a), 32'd0);
    check("run.tready", 32'(rdy_a), 32'd0);
    idle(2);
    pulse_clear_a();
    check("clr.done",   32'(done_a), 32'd0);
    check("clr.good",   32'(good_a), 32'd0);
    check("clr.tready", 32'(rdy_a), 32'd1);

    // sequence gap and resync
    send_frame(0, 16'd0, 16'd3, 3, 1'b1, -1, -1);
    send_frame(0, 16'd1, 16'd3, 3, 1'b1, -1, -1);
    send_frame(0, 16'd3, 16'd3, 3, 1'b1, -1, -1);
    send_frame(0, 16'd4, 16'd3, 3, 1'b1, -1, -1);
    idle(1);
    check("seq.good",  32'(good_a), 32'd3);
    check("seq.err",   32'(err_a), 32'd1);
    check("seq.flags", 32'(flags_a), 32'h1);
    pulse_clear_a();

    // short frame, then long frame through DROP, then a good one
    send_frame(0, 16'd0, 16'd4, 3, 1'b1, -1, -1);
    send_frame(0, 16'd1, 16'd2, 5, 1'b1, -1, -1);
    send_frame(0, 16'd2, 16'd3, 3, 1'b1, -1, -1);
    idle(1);
    check("len.err",   32'(err_a), 32'd2);
    check("len.good",  32'(good_a), 32'd1);
    check("len.flags", 32'(flags_a), 32'h2);
    pulse_clear_a();

    // mid-frame timeout after 8 idle cycles
    send_frame(0, 16'd0, 16'd5, 2, 1'b0, -1, -1);
    idle(7);
    check("tmo.err_before", 32'(err_a), 32'd0);
    idle(1);
    check("tmo.err",   32'(err_a), 32'd1);
    check("tmo.flags", 32'(flags_a), 32'h8);
    send_frame(0, 16'd1, 16'd2, 2, 1'b1, -1, -1);
    idle(1);
    check("tmo.next_good", 32'(good_a), 32'd1);
    pulse_clear_a();

    // clear coincident with a header discards it
    tdata = '0; tdata[15:0] = 16'd5; tdata[31:16] = 16'd1; last = 1'b1;
    valid_a = 1'b1; clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    idle(1);
    check("clrhdr.good",   32'(good_a), 32'd0);
    check("clrhdr.err",    32'(err_a), 32'd0);
    send_frame(0, 16'd0, 16'd1, 1, 1'b1, -1, -1);
    idle(1);
    check("clrhdr.next_good", 32'(good_a), 32'd1);
    check("clrhdr.next_err",  32'(err_a), 32'd0);

    // reset mid-frame
    send_frame(0, 16'd1, 16'd4, 2, 1'b0, -1, -1);
    valid_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid.tready", 32'(rdy_a), 32'd0);
    check("rstmid.good",   32'(good_a), 32'd0);
    check("rstmid.done_b", 32'(done_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rstmid.tready_held", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    check("rstmid.tready_up", 32'(rdy_a), 32'd1);
    send_frame(0, 16'd0, 16'd2, 2, 1'b1, -1, -1);
    idle(1);
    check("rstmid.good_after", 32'(good_a), 32'd1);
    check("rstmid.err_after",  32'(err_a), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
